// File: rtl/start_pulse_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : start_pulse_ctrl_pkg
// Description : Shared definitions for the start-pulse controller. It holds
//               the channel state encoding, the per-channel mode codes and
//               a helper that reports whether a mode is allowed to fire.
// Revision    : 1.0 - initial release
// ============================================================================
package start_pulse_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PULSE     = 2'd1,
        WAIT_DONE = 2'd2,
        SPENT     = 2'd3
    } ch_state_t;

    localparam logic [1:0] MODE_ONESHOT   = 2'b00;
    localparam logic [1:0] MODE_EDGE      = 2'b01;
    localparam logic [1:0] MODE_HANDSHAKE = 2'b10;
    localparam logic [1:0] MODE_DISABLED  = 2'b11;

    // A channel may only fire or report itself armed when it is not disabled.
    function automatic logic mode_can_fire(input logic [1:0] mode);
        return (mode != MODE_DISABLED);
    endfunction

endpackage
`default_nettype wire

// File: rtl/start_pulse_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : start_pulse_ctrl_if
// Description : Bundle between the control register file (master) and the
//               start-pulse controller (slave).
//               start/done/rearm : per-channel request, completion, re-arm
//               mode             : 2 bits per channel, ch i = mode[2i+1:2i]
//               start_out/busy/armed/overrun : per-channel status
// Revision    : 1.0 - initial release
// ============================================================================
interface start_pulse_ctrl_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0]   start;
    logic [NUM_CH-1:0]   done;
    logic [NUM_CH-1:0]   rearm;
    logic [2*NUM_CH-1:0] mode;
    logic [NUM_CH-1:0]   start_out;
    logic [NUM_CH-1:0]   busy;
    logic [NUM_CH-1:0]   armed;
    logic [NUM_CH-1:0]   overrun;

    modport master (
        output start, done, rearm, mode,
        input  start_out, busy, armed, overrun
    );

    modport slave (
        input  start, done, rearm, mode,
        output start_out, busy, armed, overrun
    );
endinterface
`default_nettype wire

// File: rtl/start_pulse_ctrl_ch.sv
`default_nettype none
// ============================================================================
// Module      : start_pulse_ch
// Description : One start-pulse channel: rising-edge detect, IDLE/PULSE/
//               WAIT_DONE/SPENT state machine, pulse-width counter, done
//               latch and sticky overrun flag.
//   clk, rst_n  : clock, synchronous active-low reset
//   i_start     : raw start level        i_done  : engine completion
//   i_rearm     : leave SPENT, clear overrun
//   i_mode      : live channel mode (latched when the channel fires)
//   o_start_out : registered start pulse, PULSE_W cycles per fire
//   o_busy      : registered, channel in PULSE or WAIT_DONE
//   o_armed     : combinational, IDLE and live mode not disabled
//   o_overrun   : registered sticky overrun flag
// Revision    : 1.0 - initial release
// ============================================================================
module start_pulse_ch
    import start_pulse_ctrl_pkg::*;
#(
    parameter int PULSE_W = 1
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       i_start,
    input  wire logic       i_done,
    input  wire logic       i_rearm,
    input  wire logic [1:0] i_mode,
    output logic            o_start_out,
    output logic            o_busy,
    output logic            o_armed,
    output logic            o_overrun
);

    localparam int CNT_W = $clog2(PULSE_W + 1);
    localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(PULSE_W - 1);

    ch_state_t        r_state;
    logic             r_start_q;
    logic [1:0]       r_mode_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done_seen;
    logic             r_overrun;
    logic             r_start_out;
    logic             r_busy;

    logic w_rise;
    logic w_fire;
    logic w_ovr_set;

    assign w_rise    = i_start & ~r_start_q;
    assign w_fire    = w_rise & mode_can_fire(i_mode);
    assign w_ovr_set = w_rise & ((r_state == PULSE) || (r_state == WAIT_DONE));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_start_q   <= 1'b0;
            r_mode_q    <= 2'b00;
            r_cnt       <= '0;
            r_done_seen <= 1'b0;
            r_overrun   <= 1'b0;
            r_start_out <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_start_q <= i_start;

            // Outputs follow the state one cycle later, giving the
            // rise -> pulse latency of two edges and exactly PULSE_W cycles.
            r_start_out <= (r_state == PULSE);
            r_busy      <= (r_state == PULSE) || (r_state == WAIT_DONE);

            // A new overrun event takes priority over a simultaneous rearm.
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (i_rearm) begin
                r_overrun <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_fire) begin
                        r_state     <= PULSE;
                        r_mode_q    <= i_mode;
                        r_cnt       <= c_CNT_LOAD;
                        r_done_seen <= 1'b0;
                    end
                end
                PULSE: begin
                    if (i_done) begin
                        r_done_seen <= 1'b1;
                    end
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        case (r_mode_q)
                            MODE_ONESHOT: r_state <= SPENT;
                            MODE_HANDSHAKE: begin
                                // done in the final pulse cycle counts as seen.
                                if (r_done_seen || i_done) begin
                                    r_state     <= IDLE;
                                    r_done_seen <= 1'b0;
                                end else begin
                                    r_state <= WAIT_DONE;
                                end
                            end
                            default: r_state <= IDLE;
                        endcase
                    end
                end
                WAIT_DONE: begin
                    if (i_done) begin
                        r_state     <= IDLE;
                        r_done_seen <= 1'b0;
                    end
                end
                SPENT: begin
                    // Rearm together with a rising edge fires immediately so
                    // the edge is not lost.
                    if (i_rearm) begin
                        if (w_fire) begin
                            r_state     <= PULSE;
                            r_mode_q    <= i_mode;
                            r_cnt       <= c_CNT_LOAD;
                            r_done_seen <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_start_out = r_start_out;
    assign o_busy      = r_busy;
    assign o_overrun   = r_overrun;
    assign o_armed     = (r_state == IDLE) && mode_can_fire(i_mode);

endmodule
`default_nettype wire

// File: rtl/start_pulse_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : start_pulse_ctrl
// Description : Multi-channel start-pulse generator for the matmul datapath.
//               NUM_CH independent start_pulse_ch instances; this level only
//               slices the bundled buses per channel.
//   clk   : clock, all logic on posedge
//   rst_n : synchronous active-low reset
//   bus   : start_pulse_ctrl_if slave (start, done, rearm, mode in;
//           start_out, busy, armed, overrun out)
// Revision    : 1.0 - initial release
// ============================================================================
module start_pulse_ctrl
    import start_pulse_ctrl_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int PULSE_W = 1
) (
    input wire logic           clk,
    input wire logic           rst_n,
    start_pulse_ctrl_if.slave  bus
);

    wire [NUM_CH-1:0] w_start_out;
    wire [NUM_CH-1:0] w_busy;
    wire [NUM_CH-1:0] w_armed;
    wire [NUM_CH-1:0] w_overrun;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        start_pulse_ch #(
            .PULSE_W (PULSE_W)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_start     (bus.start[gi]),
            .i_done      (bus.done[gi]),
            .i_rearm     (bus.rearm[gi]),
            .i_mode      (bus.mode[2*gi +: 2]),
            .o_start_out (w_start_out[gi]),
            .o_busy      (w_busy[gi]),
            .o_armed     (w_armed[gi]),
            .o_overrun   (w_overrun[gi])
        );
    end

    assign bus.start_out = w_start_out;
    assign bus.busy      = w_busy;
    assign bus.armed     = w_armed;
    assign bus.overrun   = w_overrun;

endmodule
`default_nettype wire

// File: tb/tb_start_pulse_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_start_pulse_ctrl
// Description : Directed testbench for start_pulse_ctrl. dut3 (PULSE_W = 3)
//               is driven directly; dut1 (PULSE_W = 1) mirrors the same
//               inputs and is checked in the concurrent and back-to-back cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_start_pulse_ctrl;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    start_pulse_ctrl_if #(.NUM_CH(4)) bus3 ();
    start_pulse_ctrl_if #(.NUM_CH(4)) bus1 ();

    assign bus1.start = bus3.start;
    assign bus1.done  = bus3.done;
    assign bus1.rearm = bus3.rearm;
    assign bus1.mode  = bus3.mode;

    start_pulse_ctrl #(.NUM_CH(4), .PULSE_W(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    start_pulse_ctrl #(.NUM_CH(4), .PULSE_W(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Rising edge on the channels in m is already being driven: one latency
    // cycle low, three cycles high, then low again (dut3).
    task automatic expect_pulse(input string tag, input logic [3:0] m);
        step(1);
        check_val({tag, "_lat"}, bus3.start_out & m, 4'b0000);
        for (int k = 0; k < 3; k++) begin
            step(1);
            check_val({tag, "_hi"}, bus3.start_out & m, m);
        end
        step(1);
        check_val({tag, "_end"}, bus3.start_out & m, 4'b0000);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;

        // ---------------- 1: reset, ONESHOT, SPENT, rearm ----------------
        rst_n      = 1'b0;
        bus3.start = 4'b0001;
        bus3.done  = 4'b0000;
        bus3.rearm = 4'b0000;
        bus3.mode  = 8'hFF;
        step(3);
        check_val("rst_start_out", bus3.start_out, 4'b0000);
        check_val("rst_busy",      bus3.busy,      4'b0000);
        check_val("rst_overrun",   bus3.overrun,   4'b0000);
        check_val("rst_armed",     bus3.armed,     4'b0000);

        rst_n     = 1'b1;
        bus3.mode = 8'hE4;          // ch3 DIS, ch2 HS, ch1 EDGE, ch0 ONESHOT
        expect_pulse("t1_fire", 4'b0001);
        check_val("t1_spent_armed", bus3.armed & 4'b0001, 4'b0000);

        bus3.start[0] = 1'b0;
        step(2);
        bus3.start[0] = 1'b1;
        step(1);
        for (int k = 0; k < 4; k++) begin
            step(1);
            check_val("t1_spent_nofire", bus3.start_out & 4'b0001, 4'b0000);
        end
        check_val("t1_spent_noovr", bus3.overrun & 4'b0001, 4'b0000);

        bus3.start[0] = 1'b0;
        bus3.rearm[0] = 1'b1;
        step(1);
        bus3.rearm[0] = 1'b0;
        check_val("t1_rearm_armed", bus3.armed & 4'b0001, 4'b0001);
        bus3.start[0] = 1'b1;
        expect_pulse("t1_refire", 4'b0001);
        bus3.start[0] = 1'b0;

        // ---------------- 2: EDGE mode and overrun ----------------
        for (int e = 0; e < 3; e++) begin
            bus3.start[1] = 1'b1;
            expect_pulse("t2_edge", 4'b0010);
            bus3.start[1] = 1'b0;
            step(1);
        end
        check_val("t2_noovr", bus3.overrun & 4'b0010, 4'b0000);

        bus3.start[1] = 1'b1;
        step(1);
        bus3.start[1] = 1'b0;
        step(1);
        check_val("t2_ov_hi1", bus3.start_out & 4'b0010, 4'b0010);
        bus3.start[1] = 1'b1;
        step(1);
        check_val("t2_ov_set", bus3.overrun & 4'b0010, 4'b0010);
        step(1);
        check_val("t2_ov_hi3", bus3.start_out & 4'b0010, 4'b0010);
        step(1);
        check_val("t2_ov_end", bus3.start_out & 4'b0010, 4'b0000);
        step(2);
        check_val("t2_ov_noextra", bus3.start_out & 4'b0010, 4'b0000);
        check_val("t2_ov_hold",    bus3.overrun & 4'b0010,   4'b0010);
        bus3.rearm[1] = 1'b1;
        step(1);
        bus3.rearm[1] = 1'b0;
        check_val("t2_ov_clr", bus3.overrun & 4'b0010, 4'b0000);
        bus3.start[1] = 1'b0;
        step(1);

        // ---------------- 3: HANDSHAKE ----------------
        bus3.start[2] = 1'b1;
        step(1);
        bus3.start[2] = 1'b0;
        step(3);
        check_val("t3_hi", bus3.start_out & 4'b0100, 4'b0100);
        step(1);
        check_val("t3_lo",        bus3.start_out & 4'b0100, 4'b0000);
        check_val("t3_busy_wait", bus3.busy & 4'b0100,      4'b0100);
        step(5);
        check_val("t3_wait_busy",  bus3.busy & 4'b0100,  4'b0100);
        check_val("t3_wait_armed", bus3.armed & 4'b0100, 4'b0000);
        bus3.done[2] = 1'b1;
        step(1);
        bus3.done[2] = 1'b0;
        step(1);
        check_val("t3_done_busy",  bus3.busy & 4'b0100,  4'b0000);
        check_val("t3_done_armed", bus3.armed & 4'b0100, 4'b0100);

        bus3.start[2] = 1'b1;
        step(1);
        bus3.start[2] = 1'b0;
        bus3.done[2]  = 1'b1;
        step(1);
        bus3.done[2]  = 1'b0;
        check_val("t3_ds_hi", bus3.start_out & 4'b0100, 4'b0100);
        step(2);
        check_val("t3_ds_armed", bus3.armed & 4'b0100,     4'b0100);
        check_val("t3_ds_hi3",   bus3.start_out & 4'b0100, 4'b0100);
        step(1);
        check_val("t3_ds_busy", bus3.busy & 4'b0100,      4'b0000);
        check_val("t3_ds_lo",   bus3.start_out & 4'b0100, 4'b0000);

        // ---------------- 4: DISABLED, mode change mid-pulse ----------------
        bus3.start[3] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(1);
            check_val("t4_dis_nofire", bus3.start_out & 4'b1000, 4'b0000);
        end
        check_val("t4_dis_noovr", bus3.overrun & 4'b1000, 4'b0000);
        check_val("t4_dis_busy",  bus3.busy & 4'b1000,    4'b0000);
        bus3.start[3] = 1'b0;
        step(1);

        bus3.mode[3:2] = 2'b00;     // ch1 ONESHOT for this fire
        bus3.start[1]  = 1'b1;
        step(1);
        bus3.start[1]  = 1'b0;
        step(1);
        check_val("t4_mc_hi1", bus3.start_out & 4'b0010, 4'b0010);
        bus3.mode[3:2] = 2'b01;     // switch to EDGE mid-pulse
        step(1);
        check_val("t4_mc_hi2", bus3.start_out & 4'b0010, 4'b0010);
        step(1);
        check_val("t4_mc_hi3", bus3.start_out & 4'b0010, 4'b0010);
        step(1);
        check_val("t4_mc_end",   bus3.start_out & 4'b0010, 4'b0000);
        check_val("t4_mc_spent", bus3.armed & 4'b0010,     4'b0000);
        bus3.rearm[1] = 1'b1;
        step(1);
        bus3.rearm[1] = 1'b0;
        check_val("t4_mc_rearm", bus3.armed & 4'b0010, 4'b0010);

        // ---------------- 5: reset mid-pulse ----------------
        bus3.rearm[0] = 1'b1;
        step(1);
        bus3.rearm[0] = 1'b0;
        bus3.start[0] = 1'b1;
        step(1);
        step(2);
        check_val("t5_mid", bus3.start_out & 4'b0001, 4'b0001);
        rst_n         = 1'b0;
        bus3.mode     = 8'hFF;
        bus3.start[0] = 1'b0;
        step(1);
        check_val("t5_rst_start_out", bus3.start_out, 4'b0000);
        check_val("t5_rst_busy",      bus3.busy,      4'b0000);
        check_val("t5_rst_overrun",   bus3.overrun,   4'b0000);
        check_val("t5_rst_armed",     bus3.armed,     4'b0000);
        rst_n     = 1'b1;
        bus3.mode = 8'hE4;
        for (int k = 0; k < 4; k++) begin
            step(1);
            check_val("t5_noresume", bus3.start_out, 4'b0000);
        end

        // ---------------- 6: all channels together, both widths ----------------
        bus3.mode  = 8'h64;         // ch3 EDGE, ch2 HS, ch1 EDGE, ch0 ONESHOT
        bus3.start = 4'b1111;
        step(1);
        bus3.start = 4'b0000;
        check_val("t6_w3_lat", bus3.start_out, 4'b0000);
        check_val("t6_w1_lat", bus1.start_out, 4'b0000);
        step(1);
        check_val("t6_w3_hi1", bus3.start_out, 4'b1111);
        check_val("t6_w1_hi",  bus1.start_out, 4'b1111);
        step(1);
        check_val("t6_w3_hi2",   bus3.start_out, 4'b1111);
        check_val("t6_w1_end",   bus1.start_out, 4'b0000);
        check_val("t6_w1_armed", bus1.armed,     4'b1010);
        check_val("t6_w1_busy",  bus1.busy,      4'b0100);
        step(1);
        check_val("t6_w3_hi3", bus3.start_out, 4'b1111);
        step(1);
        check_val("t6_w3_end",   bus3.start_out, 4'b0000);
        check_val("t6_w3_armed", bus3.armed,     4'b1010);
        check_val("t6_w3_busy",  bus3.busy,      4'b0100);
        bus3.done[2] = 1'b1;
        step(1);
        bus3.done[2] = 1'b0;
        step(1);
        check_val("t6_w3_done_busy",  bus3.busy,  4'b0000);
        check_val("t6_w3_done_armed", bus3.armed, 4'b1110);
        check_val("t6_w1_done_busy",  bus1.busy,  4'b0000);
        check_val("t6_w1_done_armed", bus1.armed, 4'b1110);
        bus3.rearm[0] = 1'b1;
        step(1);
        bus3.rearm[0] = 1'b0;
        check_val("t6_w3_rearm", bus3.armed, 4'b1111);
        check_val("t6_w1_rearm", bus1.armed, 4'b1111);

        // Back-to-back EDGE pulses with PULSE_W = 1, one idle cycle apart.
        bus3.start = 4'b0010;
        step(1);
        bus3.start = 4'b0000;
        step(1);
        check_val("t6_b2b_p1", bus1.start_out & 4'b0010, 4'b0010);
        bus3.start = 4'b0010;
        step(1);
        bus3.start = 4'b0000;
        check_val("t6_b2b_gap", bus1.start_out & 4'b0010, 4'b0000);
        step(1);
        check_val("t6_b2b_p2", bus1.start_out & 4'b0010, 4'b0010);
        step(1);
        check_val("t6_b2b_end", bus1.start_out & 4'b0010, 4'b0000);
        check_val("t6_b2b_noovr", bus1.overrun & 4'b0010, 4'b0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
